logic_serial_engine: RTL and testbench
======================================

# logic_serial_engine

Multi-cycle, slice-serial logic execution unit for the 8-bit ALU datapath. It accepts a logic command over a valid/ready handshake: operands A and B plus the two select bits s2/s3 that encode AND/XOR/OR/ONE'S-complement. It evaluates the result W bits per clock, LSB slice first, and presents the registered result with zero and negative flags over a valid/ready output handshake. It is the sequenced, flow-controlled counterpart to the combinational logic unit: it drives the same select encoding and produces the same RL result.

## Interface
- N, 8: operand/result width in bits.
- W, 2: bits evaluated per cycle; N must be a multiple of W, else an elaboration error is raised.
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command valid.
- in_ready  out  1  engine can accept a command.
- in_a  in  N  operand A (signed).
- in_b  in  N  operand B (signed).
- in_s2  in  1  select bit s2 (MSB of op).
- in_s3  in  1  select bit s3 (LSB of op).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_rl  out  N  result (signed).
- out_zero  out  1  out_rl == 0.
- out_neg  out  1  out_rl[N-1].

## Operation
- Op encoding {s2,s3}:
  - 00 = A & B.
  - 01 = A ^ B.
  - 10 = A | B.
  - 11 = ~B (A ignored).
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid: capture in_a, in_b, {s2,s3} into internal registers; clear slice counter; go to BUSY.
  - BUSY:
    - in_ready=0.
    - Each cycle, compute slice cnt (bits [cnt*W +: W]) from the captured operands and write it into the result register at that position; cnt++.
    - On the cycle with cnt == N/W-1, go to DONE.
  - DONE:
    - out_valid=1.
    - On out_ready: if in_valid is also high, capture the new command and go to BUSY (in_ready = out_ready in DONE); otherwise go to IDLE.
- Input pins are ignored outside an accepting handshake; changing in_a/in_b during BUSY has no effect.
- Result bits not yet written in BUSY hold the previous result's values; nothing outside the block may observe them (out_valid=0).
- out_rl, out_zero and out_neg hold stable while out_valid=1 and out_ready=0.
- out_zero and out_neg are derived combinationally from the result register.

## Timing
- Reset (synchronous):
  - State=IDLE, cnt=0.
  - out_valid=0; out_rl=0, so out_zero=1 and out_neg=0.
  - Captured operand and op registers = 0.
  - Reset asserted mid-BUSY or in DONE abandons the command; no result is produced.
- Latency: the command is accepted at edge E0; slices are written at edges E1..E(N/W); out_valid is high after E(N/W).
  - Default N=8, W=2: out_valid asserted 4 cycles after acceptance.
- Throughput with out_ready and in_valid held high: one result per N/W+1 cycles (5 for the defaults). The DONE->BUSY handoff edge is also the capture edge.
- W=N: BUSY lasts 1 cycle; latency 1, period 2.
- in_ready depends combinationally on state and out_ready only, never on in_valid.

## Structure
- Shared package `alu_pkg`:
  - Op localparams: AND=2'b00, XOR=2'b01, OR=2'b10, ONE_S=2'b11.
  - FSM state encoding: IDLE, BUSY, DONE.
- One sub-module, `logic_slice`: W-bit combinational slice that takes a[W-1:0], b[W-1:0] and op[1:0] and returns r[W-1:0].
  - It is instantiated once and fed by a counter-indexed part-select.
- Top level contains the FSM, the slice counter ($clog2(N/W) bits, min 1), the operand/op registers and the result register.

## Test plan
- AND: A=8'hF0, B=8'h3C, op=00 -> out_rl=8'h30, zero=0, neg=0; out_valid rises exactly 4 cycles after the accept edge.
- XOR and OR:
  - A=8'h5A, B=8'h5A, op=01 -> out_rl=8'h00, zero=1.
  - A=8'h81, B=8'h02, op=10 -> out_rl=8'h83, neg=1.
- ONE_S: A=8'hFF, B=8'h01, op=11 -> out_rl=8'hFE, neg=1; A has no influence.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE -> out_rl and flags stable, in_ready=0.
  - Toggle in_a/in_b throughout -> no change to the pending result.
- Back-to-back: in_valid and out_ready held high, 3 commands -> results in order, one per 5 cycles; each new command is accepted on the DONE handoff edge.
- Reset mid-BUSY (after 2 slices): out_valid stays 0, in_ready=1 next cycle, out_rl=0; a subsequent command (A=8'hAA, B=8'h0F, op=00 -> 8'h0A) completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath: logic op encoding and the serial engine FSM states.
package alu_pkg;

  localparam logic [1:0] AND   = 2'b00;
  localparam logic [1:0] XOR   = 2'b01;
  localparam logic [1:0] OR    = 2'b10;
  localparam logic [1:0] ONE_S = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/logic_slice.sv
// W-bit combinational logic slice: evaluates one op over one operand slice.
module logic_slice
  import alu_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] r
);

  always_comb begin
    r = ~b;
    case (op)
      AND:     r = a & b;
      XOR:     r = a ^ b;
      OR:      r = a | b;
      default: r = ~b;
    endcase
  end

endmodule

// File: rtl/logic_serial_engine.sv
// Slice-serial logic unit: captures a command, evaluates W bits per clock LSB first,
// then holds the result and flags behind a valid/ready output handshake.
module logic_serial_engine
  import alu_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_s2,
  input  logic         in_s3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_rl,
  output logic         out_zero,
  output logic         out_neg
);

  localparam int unsigned SLICES = N / W;
  localparam int unsigned CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  if ((N % W) != 0) begin : g_bad_width
    $error("logic_serial_engine: N must be a multiple of W");
  end

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    a_q, b_q, rl_q;
  logic [1:0]      op_q;
  logic [W-1:0]    slice_r;
  logic            accept;
  logic            last_slice;

  assign accept     = in_valid & in_ready;
  assign last_slice = (cnt_q == CW'(SLICES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a DONE handoff with a pending command goes straight back to BUSY
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last_slice) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs depend on state and out_ready only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      DONE:    begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  logic_slice #(.W(W)) u_slice (
    .a  (a_q[cnt_q*W +: W]),
    .b  (b_q[cnt_q*W +: W]),
    .op (op_q),
    .r  (slice_r)
  );

  // Operand capture and slice-by-slice result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      rl_q  <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      a_q   <= in_a;
      b_q   <= in_b;
      op_q  <= {in_s2, in_s3};
      cnt_q <= '0;
    end else if (state_q == BUSY) begin
      rl_q[cnt_q*W +: W] <= slice_r;
      cnt_q              <= cnt_q + CW'(1);
    end
  end

  assign out_rl   = rl_q;
  assign out_zero = (rl_q == '0);
  assign out_neg  = rl_q[N-1];

endmodule

// File: tb/tb_logic_serial_engine.sv
// Directed self-checking bench for logic_serial_engine (N=8, W=2).
module tb_logic_serial_engine;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_s2;
  logic       in_s3;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_rl;
  logic       out_zero;
  logic       out_neg;

  int errors = 0;
  int checks = 0;

  logic_serial_engine #(.N(8), .W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_s2     (in_s2),
    .in_s3     (in_s3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rl    (out_rl),
    .out_zero  (out_zero),
    .out_neg   (out_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    in_a  = a;
    in_b  = b;
    in_s2 = op[1];
    in_s3 = op[0];
  endtask

  // Waits (bounded) for out_valid while scrambling the operand pins
  task automatic wait_valid(output int cyc, input bit scramble);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      if (scramble) begin
        in_a = 8'($urandom);
        in_b = 8'($urandom);
      end
      step();
      cyc++;
    end
  endtask

  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input logic [7:0] exp, input string tag);
    int cyc;
    set_cmd(a, b, op);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    step();
    in_valid = 1'b0;
    wait_valid(cyc, 1'b1);
    chk({tag, "_latency"}, 32'(cyc), 32'(4));
    chk({tag, "_rl"}, 32'(out_rl), 32'(exp));
    chk({tag, "_zero"}, 32'(out_zero), 32'(exp == 8'h00));
    chk({tag, "_neg"}, 32'(out_neg), 32'(exp[7]));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drained"}, 32'(out_valid), 32'(0));
  endtask

  initial begin
    int cyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_cmd(8'h00, 8'h00, 2'b00);
    step();
    step();
    rst = 1'b0;

    chk("reset_in_ready",  32'(in_ready),  32'(1));
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_rl",        32'(out_rl),    32'(0));
    chk("reset_zero",      32'(out_zero),  32'(1));
    chk("reset_neg",       32'(out_neg),   32'(0));

    run_cmd(8'hF0, 8'h3C, 2'b00, 8'h30, "and");
    run_cmd(8'h5A, 8'h5A, 2'b01, 8'h00, "xor");
    run_cmd(8'h81, 8'h02, 2'b10, 8'h83, "or");
    run_cmd(8'hFF, 8'h01, 2'b11, 8'hFE, "ones_a_ff");
    run_cmd(8'h00, 8'h01, 2'b11, 8'hFE, "ones_a_00");

    // Backpressure: result held for 10 cycles while pins churn
    set_cmd(8'h3C, 8'h0F, 2'b10);
    in_valid = 1'b1;
    step();
    wait_valid(cyc, 1'b1);
    chk("bp_latency", 32'(cyc), 32'(4));
    for (int i = 0; i < 10; i++) begin
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      step();
      chk("bp_valid",    32'(out_valid), 32'(1));
      chk("bp_in_ready", 32'(in_ready),  32'(0));
      chk("bp_rl",       32'(out_rl),    32'(8'h3F));
      chk("bp_zero",     32'(out_zero),  32'(0));
      chk("bp_neg",      32'(out_neg),   32'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_drained", 32'(out_valid), 32'(0));

    // Back-to-back: three commands, one result per 5 cycles
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_cmd(8'hF0, 8'h3C, 2'b00);
    step();
    set_cmd(8'h12, 8'h34, 2'b01);
    wait_valid(cyc, 1'b0);
    chk("b2b0_latency",  32'(cyc),      32'(4));
    chk("b2b0_rl",       32'(out_rl),   32'(8'h30));
    chk("b2b0_in_ready", 32'(in_ready), 32'(1));
    step();
    chk("b2b1_busy", 32'(out_valid), 32'(0));
    set_cmd(8'hAA, 8'h0F, 2'b11);
    wait_valid(cyc, 1'b0);
    chk("b2b1_latency", 32'(cyc),    32'(4));
    chk("b2b1_rl",      32'(out_rl), 32'(8'h26));
    step();
    in_valid = 1'b0;
    wait_valid(cyc, 1'b0);
    chk("b2b2_latency", 32'(cyc),     32'(4));
    chk("b2b2_rl",      32'(out_rl),  32'(8'hF0));
    chk("b2b2_neg",     32'(out_neg), 32'(1));
    step();
    out_ready = 1'b0;
    chk("b2b_idle_valid", 32'(out_valid), 32'(0));
    chk("b2b_idle_ready", 32'(in_ready),  32'(1));

    // Reset after two slices abandons the command
    set_cmd(8'hFF, 8'h00, 2'b11);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_valid", 32'(out_valid), 32'(0));
    chk("rst_mid_ready", 32'(in_ready),  32'(1));
    chk("rst_mid_rl",    32'(out_rl),    32'(0));
    chk("rst_mid_zero",  32'(out_zero),  32'(1));
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rst_mid_quiet", 32'(out_valid), 32'(0));
    end
    run_cmd(8'hAA, 8'h0F, 2'b00, 8'h0A, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
